// File: rtl/pulse_train_gen_pkg.sv
// pulse_train_pkg: shared state encoding, default widths and the low-duration clamp.
package pulse_train_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int TIME_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    // A zero-length gap would merge adjacent pulses, so the shortest gap is one tick.
    function automatic logic [31:0] clamp_low(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/pulse_train_gen_tick_timer.sv
// tick_timer: counts timebase ticks after a load and flags the tick that reaches the target.
module tick_timer #(
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              tick_i,
    input  logic [TIME_W-1:0] target_i,
    output logic              expire_o
);

    logic [TIME_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc  = cnt_q + TIME_W'(1);
    assign expire_o = en_i && tick_i && (cnt_inc == target_i);

    always_comb begin
        cnt_d = load_i ? '0 : (en_i && tick_i) ? cnt_inc : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmable train of N rectangular pulses timed in timebase ticks.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [TIME_W-1:0] high_ticks_i,
    input  logic [TIME_W-1:0] low_ticks_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              pulse_out_o,
    output logic              pulse_redge_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [CNT_W-1:0]  pulses_sent_o
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d, pulse_q, pulse_d, redge_q, redge_d;
    logic              done_q, done_d, aborted_q, aborted_d;
    logic [CNT_W-1:0]  sent_q, sent_d, count_q, count_d;
    logic [TIME_W-1:0] high_q, high_d, low_q, low_d;
    logic              expire, load;

    tick_timer #(.TIME_W(TIME_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .en_i     (state_q != IDLE),
        .tick_i   (tick_i),
        .target_i ((state_q == LOW) ? low_q : high_q),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        redge_d   = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        sent_d    = sent_q;
        count_d   = count_q;
        high_d    = high_q;
        low_d     = low_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i && count_i != '0 && high_ticks_i != '0) begin
                    state_d = HIGH;
                    redge_d = 1'b1;
                    sent_d  = CNT_W'(1);
                    count_d = count_i;
                    high_d  = high_ticks_i;
                    low_d   = TIME_W'(clamp_low(32'(low_ticks_i)));
                end
            end
            HIGH: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (expire) begin
                    state_d = (sent_q == count_q) ? IDLE : LOW;
                    done_d  = (sent_q == count_q);
                end
            end
            LOW: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (expire) begin
                    state_d = HIGH;
                    redge_d = 1'b1;
                    sent_d  = sent_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
        load    = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
            redge_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            sent_q    <= '0;
            count_q   <= '0;
            high_q    <= '0;
            low_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            pulse_q   <= pulse_d;
            redge_q   <= redge_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            sent_q    <= sent_d;
            count_q   <= count_d;
            high_q    <= high_d;
            low_q     <= low_d;
        end
    end

    assign busy_o        = busy_q;
    assign pulse_out_o   = pulse_q;
    assign pulse_redge_o = redge_q;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign pulses_sent_o = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed scenarios for pulse_train_gen with hand-computed expectations.
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  count_i = '0;
    logic [15:0] high_ticks_i = '0;
    logic [15:0] low_ticks_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, pulse_out_o, pulse_redge_o, done_o, aborted_o;
    logic [7:0]  pulses_sent_o;

    int tests = 0;
    int fails = 0;

    pulse_train_gen #(.CNT_W(8), .TIME_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_i        (tick_i),
        .start_i       (start_i),
        .count_i       (count_i),
        .high_ticks_i  (high_ticks_i),
        .low_ticks_i   (low_ticks_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .pulse_out_o   (pulse_out_o),
        .pulse_redge_o (pulse_redge_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o),
        .pulses_sent_o (pulses_sent_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench observing the first cycle after the accepting edge.
    task automatic start_train(input logic [7:0] c, input logic [15:0] h, input logic [15:0] l);
        count_i = c;
        high_ticks_i = h;
        low_ticks_i = l;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        #12;
        obs = {busy_o, pulse_out_o, pulse_redge_o, done_o, aborted_o, |pulses_sent_o};
        tests++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 000000", obs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_train;
        logic [13:0] pv, rv, dv, bv;
        start_train(8'd3, 16'd2, 16'd3);
        count_i = 8'd7;
        high_ticks_i = 16'd9;
        low_ticks_i = 16'd0;
        for (int i = 0; i < 14; i++) begin
            pv[13-i] = pulse_out_o;
            rv[13-i] = pulse_redge_o;
            dv[13-i] = done_o;
            bv[13-i] = busy_o;
            step();
        end
        tests++;
        if (pv !== 14'b11000110001100) begin
            fails++;
            $display("FAIL basic_pulse: got %b expected 11000110001100", pv);
        end
        tests++;
        if (rv !== 14'b10000100001000) begin
            fails++;
            $display("FAIL basic_redge: got %b expected 10000100001000", rv);
        end
        tests++;
        if (dv !== 14'b00000000000010) begin
            fails++;
            $display("FAIL basic_done: got %b expected 00000000000010", dv);
        end
        tests++;
        if (bv !== 14'b11111111111100) begin
            fails++;
            $display("FAIL basic_busy: got %b expected 11111111111100", bv);
        end
        tests++;
        if (pulses_sent_o !== 8'd3) begin
            fails++;
            $display("FAIL basic_sent: got %0d expected 3", pulses_sent_o);
        end
    endtask

    task automatic test_slow_tick(input int phase, input int exp_high);
        int hi, dn, mis;
        hi = 0;
        dn = 0;
        mis = 0;
        tick_i = (phase == 0);
        start_train(8'd1, 16'd2, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            hi += int'(pulse_out_o);
            dn += int'(done_o);
            if (busy_o !== pulse_out_o) mis++;
            tick_i = ((k % 4) == phase);
            step();
        end
        tick_i = 1'b1;
        tests++;
        if (hi != exp_high) begin
            fails++;
            $display("FAIL slow_tick_high phase %0d: got %0d cycles expected %0d", phase, hi, exp_high);
        end
        tests++;
        if (dn != 1) begin
            fails++;
            $display("FAIL slow_tick_done phase %0d: got %0d strobes expected 1", phase, dn);
        end
        tests++;
        if (mis != 0) begin
            fails++;
            $display("FAIL slow_tick_busy phase %0d: busy differed from pulse_out in %0d cycles expected 0", phase, mis);
        end
    endtask

    task automatic test_low_clamp;
        logic [5:0] pv, rv, dv;
        start_train(8'd2, 16'd1, 16'd0);
        for (int i = 0; i < 6; i++) begin
            pv[5-i] = pulse_out_o;
            rv[5-i] = pulse_redge_o;
            dv[5-i] = done_o;
            step();
        end
        tests++;
        if (pv !== 6'b101000) begin
            fails++;
            $display("FAIL clamp_pulse: got %b expected 101000", pv);
        end
        tests++;
        if (rv !== 6'b101000) begin
            fails++;
            $display("FAIL clamp_redge: got %b expected 101000", rv);
        end
        tests++;
        if (dv !== 6'b000100) begin
            fails++;
            $display("FAIL clamp_done: got %b expected 000100", dv);
        end
        tests++;
        if (pulses_sent_o !== 8'd2) begin
            fails++;
            $display("FAIL clamp_sent: got %0d expected 2", pulses_sent_o);
        end
    endtask

    task automatic test_abort;
        logic [4:0] obs;
        int act;
        start_train(8'd5, 16'd4, 16'd4);
        for (int i = 0; i < 13; i++) step();
        tests++;
        if (pulse_out_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_in_low: got pulse=%b busy=%b expected pulse=0 busy=1", pulse_out_o, busy_o);
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        obs = {pulse_out_o, busy_o, done_o, aborted_o, pulse_redge_o};
        tests++;
        if (obs !== 5'b00110) begin
            fails++;
            $display("FAIL abort_strobe: got pulse,busy,done,aborted,redge=%b expected 00110", obs);
        end
        tests++;
        if (pulses_sent_o !== 8'd2) begin
            fails++;
            $display("FAIL abort_sent: got %0d expected 2", pulses_sent_o);
        end
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            act += int'(pulse_out_o | busy_o | done_o | aborted_o);
        end
        tests++;
        if (act != 0 || pulses_sent_o !== 8'd2) begin
            fails++;
            $display("FAIL abort_after: got %0d active cycles sent=%0d expected 0 active sent=2", act, pulses_sent_o);
        end
    endtask

    task automatic test_reject;
        int act, hi, dn;
        for (int c = 0; c < 3; c++) begin
            act = 0;
            abort_i = (c == 2);
            start_train((c == 0) ? 8'd0 : 8'd2, (c == 1) ? 16'd0 : 16'd2, 16'd1);
            abort_i = 1'b0;
            for (int i = 0; i < 5; i++) begin
                act += int'(busy_o | done_o | pulse_out_o);
                step();
            end
            tests++;
            if (act != 0) begin
                fails++;
                $display("FAIL reject_case%0d: got %0d active cycles expected 0", c, act);
            end
        end
        hi = 0;
        dn = 0;
        start_train(8'd1, 16'd3, 16'd1);
        count_i = 8'd2;
        high_ticks_i = 16'd1;
        start_i = 1'b1;
        hi += int'(pulse_out_o);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            hi += int'(pulse_out_o);
            dn += int'(done_o);
            step();
        end
        tests++;
        if (hi != 3 || dn != 1 || pulses_sent_o !== 8'd1) begin
            fails++;
            $display("FAIL reject_busy: got high=%0d done=%0d sent=%0d expected 3 1 1", hi, dn, pulses_sent_o);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        start_train(8'd1, 16'd10, 16'd1);
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (pulse_out_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got pulse=%b busy=%b expected 0 0", pulse_out_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            dn += int'(done_o);
        end
        rst_n = 1'b1;
        step();
        dn += int'(done_o);
        tests++;
        if (dn != 0) begin
            fails++;
            $display("FAIL reset_mid_done: got %0d done strobes expected 0", dn);
        end
        start_train(8'd1, 16'd1, 16'd0);
        tests++;
        if (pulse_out_o !== 1'b1 || pulse_redge_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_restart_high: got pulse=%b redge=%b expected 1 1", pulse_out_o, pulse_redge_o);
        end
        step();
        tests++;
        if (pulse_out_o !== 1'b0 || done_o !== 1'b1 || aborted_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_restart_done: got pulse=%b done=%b aborted=%b expected 0 1 0", pulse_out_o, done_o, aborted_o);
        end
        step();
    endtask

    task automatic test_back_to_back;
        logic [4:0] pv, dv;
        start_train(8'd1, 16'd1, 16'd0);
        pv[4] = pulse_out_o;
        dv[4] = done_o;
        step();
        pv[3] = pulse_out_o;
        dv[3] = done_o;
        high_ticks_i = 16'd2;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        tests++;
        if (pulse_redge_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_redge: got %b expected 1", pulse_redge_o);
        end
        for (int i = 2; i >= 0; i--) begin
            pv[i] = pulse_out_o;
            dv[i] = done_o;
            step();
        end
        tests++;
        if (pv !== 5'b10110 || dv !== 5'b01001) begin
            fails++;
            $display("FAIL b2b_pattern: got pulse=%b done=%b expected 10110 01001", pv, dv);
        end
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_slow_tick(0, 8);
        test_slow_tick(1, 5);
        test_low_clamp();
        test_abort();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
